vga_timing_decoder: RTL and testbench

//  Receive end of the VGA sync interface. Samples an incoming active-low h_sync/v_sync pair, one sample per clk.

---
 rtl/vga_timing_decoder.sv | 130 +++++++++++++
 tb/tb_vga_timing_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA sync decoder: rebuilds x/y/video_on from active-low sync edges
// and verifies line/frame periods against the configured timing before asserting lock.
module vga_timing_decoder #(
   parameter int HD = 640,
   parameter int HF = 16,
   parameter int HB = 48,
   parameter int HR = 96,
   parameter int VD = 480,
   parameter int VF = 10,
   parameter int VB = 33,
   parameter int VR = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       h_sync,
   input  logic       v_sync,
   output logic [9:0] x_loc,
   output logic [9:0] y_loc,
   output logic       video_on,
   output logic       locked,
   output logic       frame_start,
   output logic       sync_err
);

   localparam int H_TOTAL = HD + HF + HB + HR;
   localparam int V_TOTAL = VD + VF + VB + VR;
   localparam int PW      = $clog2(H_TOTAL + 2);
   localparam int LW      = $clog2(V_TOTAL + 2);

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   state_t          state, state_nx;
   logic            prev_h, prev_v;
   logic [PW-1:0]   per_cnt;
   logic [LW-1:0]   line_cnt;
   logic            meas_valid, meas_nx;
   logic            h_fall, v_fall, bad_line, frame_good, err_nx;
   logic [9:0]      x_nx, y_nx;

   always_comb begin
      h_fall     = prev_h & ~h_sync;
      v_fall     = prev_v & ~v_sync;
      // per_cnt holds clocks elapsed since the last h_sync fall
      bad_line   = meas_valid && (h_fall ? (per_cnt != PW'(H_TOTAL))
                                         : (per_cnt == PW'(H_TOTAL)));
      frame_good = (line_cnt == LW'(V_TOTAL));

      if (h_fall)
         x_nx = 10'(HD + HF);
      else if (x_loc == 10'(H_TOTAL - 1))
         x_nx = '0;
      else
         x_nx = x_loc + 10'd1;

      if (v_fall)
         y_nx = 10'(VD + VF);
      else if (!h_fall && x_loc == 10'(H_TOTAL - 1))
         y_nx = (y_loc == 10'(V_TOTAL - 1)) ? '0 : y_loc + 10'd1;
      else
         y_nx = y_loc;

      state_nx = state;
      err_nx   = 1'b0;
      meas_nx  = meas_valid | h_fall;
      case (state)
         SEARCH: begin
            // The first h_sync fall seen in CHECK only opens measurement
            meas_nx = v_fall ? h_fall : 1'b0;
            if (v_fall)
               state_nx = CHECK;
         end
         CHECK: begin
            if (bad_line || (v_fall && !frame_good)) begin
               err_nx   = 1'b1;
               state_nx = SEARCH;
            end else if (v_fall) begin
               state_nx = LOCKED;
            end
         end
         LOCKED: begin
            if (bad_line || (v_fall && !frame_good)) begin
               err_nx   = 1'b1;
               state_nx = SEARCH;
            end
         end
         default: state_nx = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEARCH;
         prev_h      <= 1'b1;
         prev_v      <= 1'b1;
         per_cnt     <= '0;
         line_cnt    <= '0;
         meas_valid  <= 1'b0;
         x_loc       <= '0;
         y_loc       <= '0;
         video_on    <= 1'b0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state      <= state_nx;
         prev_h     <= h_sync;
         prev_v     <= v_sync;
         meas_valid <= meas_nx;

         if (h_fall)
            per_cnt <= PW'(1);
         else if (per_cnt != PW'(H_TOTAL + 1))
            per_cnt <= per_cnt + PW'(1);

         // An h_sync fall coincident with a v_sync fall is line 1 of the new frame
         if (v_fall)
            line_cnt <= {{(LW-1){1'b0}}, h_fall};
         else if (h_fall && line_cnt != LW'(V_TOTAL + 1))
            line_cnt <= line_cnt + LW'(1);

         x_loc       <= x_nx;
         y_loc       <= y_nx;
         locked      <= (state_nx == LOCKED);
         video_on    <= (state_nx == LOCKED) && (x_nx < 10'(HD)) && (y_nx < 10'(VD));
         frame_start <= (x_nx == '0) && (y_nx == '0);
         sync_err    <= err_nx;
      end
   end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder using a shrunken 16x13 raster so several frames fit in a short run.
module tb_vga_timing_decoder;

   localparam int HD  = 8;
   localparam int HF  = 2;
   localparam int HB  = 3;
   localparam int HR  = 3;
   localparam int VD  = 6;
   localparam int VF  = 2;
   localparam int VB  = 3;
   localparam int VR  = 2;
   localparam int H_T = HD + HF + HB + HR;   // 16
   localparam int V_T = VD + VF + VB + VR;   // 13
   localparam int HS0 = HD + HF;             // 10
   localparam int HS1 = HD + HF + HR - 1;    // 12
   localparam int VS0 = VD + VF;             // 8
   localparam int VS1 = VD + VF + VR - 1;    // 9
   localparam int FRAME = H_T * V_T;         // 208

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       h_sync = 1'b1;
   logic       v_sync = 1'b1;
   logic [9:0] x_loc, y_loc;
   logic       video_on, locked, frame_start, sync_err;

   vga_timing_decoder #(
      .HD(HD), .HF(HF), .HB(HB), .HR(HR),
      .VD(VD), .VF(VF), .VB(VB), .VR(VR)
   ) dut (
      .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
      .x_loc(x_loc), .y_loc(y_loc), .video_on(video_on), .locked(locked),
      .frame_start(frame_start), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst; bit hs; bit vs;
      int x; int y; bit vo; bit lk; bit fs; bit err;
   } vec_t;

   vec_t vecs[13];

   int n_chk = 0;
   int n_fail = 0;

   int   h_cnt, v_cnt, vf_seen, fs_cnt;
   logic src_prev_v;
   bit   exp_lock, chk_xy, h_dly, skip_line, vs_align;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (src h=%0d v=%0d)", name, act, exp, h_cnt, v_cnt);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic src_h();
      if (h_dly && h_cnt == HS0) return 1'b1;
      return !(h_cnt >= HS0 && h_cnt <= HS1);
   endfunction

   function automatic logic src_v();
      bit low;
      if (vs_align)
         low = (v_cnt == VS0 && h_cnt >= HS0) || (v_cnt > VS0 && v_cnt <= VS1) ||
               (v_cnt == VS1 + 1 && h_cnt < HS0);
      else
         low = (v_cnt >= VS0 && v_cnt <= VS1);
      return !low;
   endfunction

   // Drives the current source sample; returns 1 when it is a v_sync fall
   task automatic drive(output bit vf);
      h_sync = src_h();
      v_sync = src_v();
      vf = src_prev_v && !v_sync;
      src_prev_v = v_sync;
   endtask

   task automatic advance();
      if (h_cnt == H_T - 1) begin
         h_cnt = 0;
         h_dly = 1'b0;
         if (skip_line && v_cnt == 4) begin
            v_cnt = 6;
            skip_line = 1'b0;
         end else begin
            v_cnt = (v_cnt + 1) % V_T;
         end
      end else begin
         h_cnt++;
      end
   endtask

   task automatic stream(input int n);
      bit vf;
      for (int i = 0; i < n; i++) begin
         drive(vf);
         if (vf) begin
            vf_seen++;
            if (vf_seen >= 2) exp_lock = 1'b1;
         end
         tick();
         chk("locked", locked, exp_lock);
         chk("sync_err", sync_err, 0);
         if (exp_lock && chk_xy) begin
            chk("x_loc", x_loc, h_cnt);
            chk("y_loc", y_loc, v_cnt);
            chk("video_on", video_on, (h_cnt < HD && v_cnt < VD));
            chk("frame_start", frame_start, (h_cnt == 0 && v_cnt == 0));
         end
         fs_cnt += int'(frame_start);
         advance();
      end
   endtask

   task automatic stream_to(input int v, input int h);
      int budget = 4 * FRAME;
      while (!(h_cnt == h && v_cnt == v) && budget > 0) begin
         stream(1);
         budget--;
      end
      if (budget == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL stream_to: position v=%0d h=%0d not reached", v, h);
      end
   endtask

   task automatic restart(input bit align);
      reset = 1'b1;
      h_sync = 1'b1;
      v_sync = 1'b1;
      tick();
      tick();
      h_cnt = 0; v_cnt = 0; vf_seen = 0; fs_cnt = 0;
      src_prev_v = 1'b1;
      exp_lock = 1'b0; chk_xy = 1'b1; h_dly = 1'b0; skip_line = 1'b0;
      vs_align = align;
      reset = 1'b0;
   endtask

   initial begin
      bit vf;
      // rst hs vs | x y vo lk fs err
      vecs[0]  = '{1, 1, 1,  0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1, 1, 1,  0, 0, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 1,  0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 1, 1,  1, 0, 0, 0, 0, 0};
      vecs[4]  = '{0, 1, 1,  2, 0, 0, 0, 0, 0};
      vecs[5]  = '{0, 0, 1, 10, 0, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 1, 11, 0, 0, 0, 0, 0};
      vecs[7]  = '{0, 1, 1, 12, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 1, 0, 13, 8, 0, 0, 0, 0};
      vecs[9]  = '{0, 1, 0, 14, 8, 0, 0, 0, 0};
      vecs[10] = '{0, 1, 1, 15, 8, 0, 0, 0, 0};
      vecs[11] = '{0, 1, 1,  0, 9, 0, 0, 0, 0};
      vecs[12] = '{0, 1, 1,  1, 9, 0, 0, 0, 0};

      h_cnt = 0; v_cnt = 0;
      for (int i = 0; i < 13; i++) begin
         reset  = vecs[i].rst;
         h_sync = vecs[i].hs;
         v_sync = vecs[i].vs;
         tick();
         chk($sformatf("vec%0d x_loc", i), x_loc, vecs[i].x);
         chk($sformatf("vec%0d y_loc", i), y_loc, vecs[i].y);
         chk($sformatf("vec%0d video_on", i), video_on, vecs[i].vo);
         chk($sformatf("vec%0d locked", i), locked, vecs[i].lk);
         chk($sformatf("vec%0d frame_start", i), frame_start, vecs[i].fs);
         chk($sformatf("vec%0d sync_err", i), sync_err, vecs[i].err);
      end

      // Ideal stream: lock one cycle after the second v_sync fall, then track
      restart(1'b0);
      stream(400);
      fs_cnt = 0;
      stream(2 * FRAME);
      chk("frame_start per 2 frames", fs_cnt, 2);
      chk("locked steady", locked, 1);

      // One h_sync fall late by a clock: overrun error at the nominal fall time
      stream_to(3, 0);
      h_dly = 1'b1;
      stream(HS0);
      drive(vf);
      tick();
      chk("late fall sync_err", sync_err, 1);
      chk("late fall locked", locked, 0);
      chk("late fall video_on", video_on, 0);
      advance();
      exp_lock = 1'b0;
      vf_seen = 0;
      stream(2 * FRAME);
      chk("relock after late fall", locked, 1);

      // Frame missing one line: error at the v_sync fall that closes it
      stream_to(2, 0);
      skip_line = 1'b1;
      chk_xy = 1'b0;
      stream_to(VS0, 0);
      drive(vf);
      tick();
      chk("short frame vfall seen", vf, 1);
      chk("short frame sync_err", sync_err, 1);
      chk("short frame locked", locked, 0);
      chk("short frame y realign", y_loc, VD + VF);
      advance();
      exp_lock = 1'b0;
      vf_seen = 0;
      chk_xy = 1'b1;
      stream(2 * FRAME + H_T);
      chk("relock after short frame", locked, 1);

      // Reset while locked mid-frame
      stream_to(4, 5);
      reset = 1'b1;
      drive(vf);
      tick();
      chk("mid reset x_loc", x_loc, 0);
      chk("mid reset y_loc", y_loc, 0);
      chk("mid reset video_on", video_on, 0);
      chk("mid reset locked", locked, 0);
      chk("mid reset frame_start", frame_start, 0);
      chk("mid reset sync_err", sync_err, 0);
      advance();
      reset = 1'b0;
      src_prev_v = 1'b1;
      exp_lock = 1'b0;
      vf_seen = 0;
      stream(100);

      // v_sync falls on the same cycle as h_sync: that line belongs to the new frame
      restart(1'b1);
      stream_to(VS0, HS0);
      stream(1);
      chk("coincident fall x_loc", x_loc, HD + HF);
      chk("coincident fall y_loc", y_loc, VD + VF);
      stream_to(VS0, HS0);
      stream(1);
      chk("coincident in CHECK x_loc", x_loc, HD + HF);
      chk("coincident in CHECK y_loc", y_loc, VD + VF);
      chk("coincident in CHECK locked", locked, 1);
      chk("coincident in CHECK sync_err", sync_err, 0);
      stream(FRAME);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
